opsum_requant: RTL and testbench

Post-processing stage directly downstream of the PE array's opsum port: it consumes 32-bit signed partial sums over a valid/ready handshake. Each sum is requantized to uint8 using a multiply, a rounding right-shift, a zero-point add and a saturation step. Four results are packed per 32-bit word in the byte order the PE uses when it splits ifmap words, and words are streamed to the GLB writer. One configuration covers one tile of `cfg_count` outputs; `done` pulses when the tile has fully drained.

---
 rtl/opsum_requant_pkg.sv | 31 +++
 rtl/opsum_requant_if.sv | 22 ++
 rtl/opsum_requant_lane.sv | 109 ++++++++++
 rtl/opsum_requant.sv | 205 ++++++++++++++++++++
 tb/tb_opsum_requant.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/opsum_requant_pkg.sv
// Shared types, widths and helpers for the opsum requantizer.
package opsum_requant_pkg;

    localparam int DATA_BITS_DEF = 32;
    localparam int PROD_BITS     = 48;
    localparam int BYTE_BITS     = 8;
    localparam int LANE_BITS     = 2;

    localparam logic [LANE_BITS-1:0] LANE_FIRST = 2'd0;
    localparam logic [LANE_BITS-1:0] LANE_LAST  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Saturate a signed value to the uint8 range [0, 255].
    function automatic logic [BYTE_BITS-1:0] sat_u8(input logic signed [PROD_BITS:0] v);
        logic [BYTE_BITS-1:0] res;
        if (v[PROD_BITS]) begin
            res = 8'd0;
        end else if (|v[PROD_BITS-1:BYTE_BITS]) begin
            res = 8'hFF;
        end else begin
            res = v[BYTE_BITS-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/opsum_requant_if.sv
// Psum input stream and packed ofmap output stream of the requantizer.
interface opsum_requant_if #(
    parameter int DATA_BITS = 32
);
    logic [DATA_BITS-1:0] psum;
    logic                 psum_valid;
    logic                 psum_ready;
    logic [DATA_BITS-1:0] ofmap;
    logic                 ofmap_valid;
    logic                 ofmap_last;
    logic                 ofmap_ready;

    modport master (
        output psum, psum_valid, ofmap_ready,
        input  psum_ready, ofmap, ofmap_valid, ofmap_last
    );

    modport slave (
        input  psum, psum_valid, ofmap_ready,
        output psum_ready, ofmap, ofmap_valid, ofmap_last
    );
endinterface

// File: rtl/opsum_requant_lane.sv
// Two-stage multiply / round / zero-point / clamp datapath with a shared stall enable.
// Defining OPSUM_REQUANT_RELU_EN clamps the rounded value at 0 before the zero-point add.
module requant_lane
    import opsum_requant_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int SCALE_BITS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic                         in_tag,
    input  logic signed [DATA_BITS-1:0]  psum,
    input  logic signed [SCALE_BITS-1:0] scale,
    input  logic [4:0]                   shift,
    input  logic [BYTE_BITS-1:0]         zero_point,
    output logic                         out_valid,
    output logic                         out_tag,
    output logic [BYTE_BITS-1:0]         out_byte,
    output logic                         pipe_busy
);

    logic                        s1_valid_q, s1_valid_d;
    logic                        s1_tag_q, s1_tag_d;
    logic signed [PROD_BITS-1:0] prod_q, prod_d;
    logic                        s2_valid_q, s2_valid_d;
    logic                        s2_tag_q, s2_tag_d;
    logic [BYTE_BITS-1:0]        byte_q, byte_d;
    logic signed [PROD_BITS-1:0] rnd_s;
    logic signed [PROD_BITS-1:0] r_raw_s;
    logic signed [PROD_BITS-1:0] r_s;
    logic signed [PROD_BITS:0]   v_s;

    // Stage 1: sign-extend and multiply by the scale.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_tag_d   = s1_tag_q;
        prod_d     = prod_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_tag_d   = in_tag;
            if (in_valid) begin
                prod_d = PROD_BITS'(psum) * PROD_BITS'(scale);
            end else begin
                prod_d = prod_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2: round-half-up shift, optional ReLU, zero-point add and saturation.
    always_comb begin
        rnd_s = '0;
        if (shift != 5'd0) begin
            rnd_s = $signed({{(PROD_BITS-1){1'b0}}, 1'b1} << (shift - 5'd1));
        end else begin
            rnd_s = '0;
        end
        r_raw_s = (prod_q + rnd_s) >>> shift;
`ifdef OPSUM_REQUANT_RELU_EN
        if (r_raw_s[PROD_BITS-1]) begin
            r_s = '0;
        end else begin
            r_s = r_raw_s;
        end
`else
        r_s = r_raw_s;
`endif
        v_s = {r_s[PROD_BITS-1], r_s} + {{(PROD_BITS+1-BYTE_BITS){1'b0}}, zero_point};

        s2_valid_d = s2_valid_q;
        s2_tag_d   = s2_tag_q;
        byte_d     = byte_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_tag_d   = s1_tag_q;
            byte_d     = sat_u8(v_s);
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Stage registers; cleared immediately on reset so no in-flight data survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= 1'b0;
            prod_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= 1'b0;
            byte_q     <= 8'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            prod_q     <= prod_d;
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
            byte_q     <= byte_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_tag   = s2_tag_q;
    assign out_byte  = byte_q;
    assign pipe_busy = s1_valid_q | s2_valid_q;

endmodule

// File: rtl/opsum_requant.sv
// Requantizes signed partial sums to uint8 and packs four per word, first element in [7:0].
// Optional ReLU stage is enabled by defining OPSUM_REQUANT_RELU_EN.
module opsum_requant
    import opsum_requant_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int SCALE_BITS = 16,
    parameter int CNT_BITS   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_en,
    input  logic [SCALE_BITS-1:0] cfg_scale,
    input  logic [4:0]            cfg_shift,
    input  logic [7:0]            cfg_zero_point,
    input  logic [CNT_BITS-1:0]   cfg_count,
    opsum_requant_if.slave        bus,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [SCALE_BITS-1:0]   scale_q, scale_d;
    logic [4:0]              shift_q, shift_d;
    logic [7:0]              zp_q, zp_d;
    logic [CNT_BITS-1:0]     count_q, count_d;
    logic [CNT_BITS-1:0]     elem_cnt_q, elem_cnt_d;
    logic [LANE_BITS-1:0]    byte_cnt_q, byte_cnt_d;
    logic [DATA_BITS-1:0]    pack_q, pack_d;
    logic [DATA_BITS-1:0]    ofmap_q, ofmap_d;
    logic                    ofmap_valid_q, ofmap_valid_d;
    logic                    ofmap_last_q, ofmap_last_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    logic                    stall_s;
    logic                    psum_ready_s;
    logic                    accept_s;
    logic                    start_s;
    logic                    elem_last_s;
    logic                    drain_s;
    logic [CNT_BITS-1:0]     cnt_eff_s;
    logic [DATA_BITS-1:0]    word_s;
    logic                    lane_valid_s;
    logic                    lane_tag_s;
    logic [BYTE_BITS-1:0]    lane_byte_s;
    logic                    pipe_busy_s;

    // Handshake decode; a held output word freezes the whole pipeline.
    always_comb begin
        stall_s      = ofmap_valid_q & ~bus.ofmap_ready;
        psum_ready_s = (state_q == ST_RUN) & ~stall_s;
        accept_s     = psum_ready_s & bus.psum_valid;
        start_s      = (state_q == ST_IDLE) & cfg_en;
        cnt_eff_s    = (count_q == {CNT_BITS{1'b0}}) ? CNT_ONE : count_q;
        elem_last_s  = (elem_cnt_q == (cnt_eff_s - CNT_ONE));
        drain_s      = (state_q == ST_FLUSH) & ~pipe_busy_s & ofmap_valid_q
                       & ofmap_last_q & bus.ofmap_ready;
    end

    requant_lane #(
        .DATA_BITS  (DATA_BITS),
        .SCALE_BITS (SCALE_BITS)
    ) u_lane (
        .clk        (clk),
        .rst        (rst),
        .en         (~stall_s),
        .in_valid   (accept_s),
        .in_tag     (elem_last_s),
        .psum       ($signed(bus.psum)),
        .scale      ($signed(scale_q)),
        .shift      (shift_q),
        .zero_point (zp_q),
        .out_valid  (lane_valid_s),
        .out_tag    (lane_tag_s),
        .out_byte   (lane_byte_s),
        .pipe_busy  (pipe_busy_s)
    );

    // Tile FSM, config capture and element counting.
    always_comb begin
        state_d    = state_q;
        scale_d    = scale_q;
        shift_d    = shift_q;
        zp_d       = zp_q;
        count_d    = count_q;
        elem_cnt_d = elem_cnt_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d    = ST_RUN;
                    scale_d    = cfg_scale;
                    shift_d    = cfg_shift;
                    zp_d       = cfg_zero_point;
                    count_d    = cfg_count;
                    elem_cnt_d = {CNT_BITS{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    elem_cnt_d = elem_cnt_q + CNT_ONE;
                    if (elem_last_s) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (drain_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Byte packer; a word may be handed off and the cleared register refilled in one cycle.
    always_comb begin
        pack_d        = pack_q;
        byte_cnt_d    = byte_cnt_q;
        ofmap_d       = ofmap_q;
        ofmap_valid_d = ofmap_valid_q;
        ofmap_last_d  = ofmap_last_q;
        word_s        = pack_q;
        word_s[byte_cnt_q*BYTE_BITS +: BYTE_BITS] = lane_byte_s;
        if (start_s) begin
            pack_d     = {DATA_BITS{1'b0}};
            byte_cnt_d = LANE_FIRST;
        end else if (!stall_s) begin
            ofmap_valid_d = 1'b0;
            ofmap_last_d  = 1'b0;
            if (lane_valid_s) begin
                if ((byte_cnt_q == LANE_LAST) || lane_tag_s) begin
                    ofmap_d       = word_s;
                    ofmap_valid_d = 1'b1;
                    ofmap_last_d  = lane_tag_s;
                    pack_d        = {DATA_BITS{1'b0}};
                    byte_cnt_d    = LANE_FIRST;
                end else begin
                    pack_d     = word_s;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end else begin
                pack_d = pack_q;
            end
        end else begin
            ofmap_valid_d = ofmap_valid_q;
        end
    end

    // Control, packer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            scale_q       <= {SCALE_BITS{1'b0}};
            shift_q       <= 5'd0;
            zp_q          <= 8'd0;
            count_q       <= {CNT_BITS{1'b0}};
            elem_cnt_q    <= {CNT_BITS{1'b0}};
            byte_cnt_q    <= LANE_FIRST;
            pack_q        <= {DATA_BITS{1'b0}};
            ofmap_q       <= {DATA_BITS{1'b0}};
            ofmap_valid_q <= 1'b0;
            ofmap_last_q  <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            scale_q       <= scale_d;
            shift_q       <= shift_d;
            zp_q          <= zp_d;
            count_q       <= count_d;
            elem_cnt_q    <= elem_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            pack_q        <= pack_d;
            ofmap_q       <= ofmap_d;
            ofmap_valid_q <= ofmap_valid_d;
            ofmap_last_q  <= ofmap_last_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.psum_ready  = psum_ready_s;
    assign bus.ofmap       = ofmap_q;
    assign bus.ofmap_valid = ofmap_valid_q;
    assign bus.ofmap_last  = ofmap_last_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_opsum_requant.sv
// Randomized bench for opsum_requant with an arithmetic reference model and word scoreboard.
module tb_opsum_requant;

    localparam int DATA_BITS  = 32;
    localparam int SCALE_BITS = 16;
    localparam int CNT_BITS   = 10;

    logic                  clk;
    logic                  rst;
    logic                  cfg_en;
    logic [SCALE_BITS-1:0] cfg_scale;
    logic [4:0]            cfg_shift;
    logic [7:0]            cfg_zero_point;
    logic [CNT_BITS-1:0]   cfg_count;
    logic                  busy;
    logic                  done;

    int          n_checks;
    int          n_errors;
    longint      cyc;
    int          rdy_mode;
    int          done_cnt;
    longint      last_acc_cyc;
    longint      last_word_cyc;
    logic [32:0] exp_q[$];

    opsum_requant_if #(.DATA_BITS(DATA_BITS)) bus ();

    opsum_requant #(
        .DATA_BITS  (DATA_BITS),
        .SCALE_BITS (SCALE_BITS),
        .CNT_BITS   (CNT_BITS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_en         (cfg_en),
        .cfg_scale      (cfg_scale),
        .cfg_shift      (cfg_shift),
        .cfg_zero_point (cfg_zero_point),
        .cfg_count      (cfg_count),
        .bus            (bus),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: requantize one psum straight from the arithmetic rules.
    function automatic logic [7:0] ref_byte(input int ps, input int sc, input int sh, input int zp);
        longint p;
        longint r;
        longint v;
        p = longint'(ps) * longint'(sc);
        if (sh == 0) r = p;
        else r = (p + (longint'(1) << (sh - 1))) >>> sh;
`ifdef OPSUM_REQUANT_RELU_EN
        if (r < 0) r = 0;
`endif
        v = r + zp;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    task automatic model_tile(input logic [15:0] sc, input logic [4:0] sh, input logic [7:0] zp,
                              input int ps[$]);
        logic [31:0] w;
        int lane;
        w = 32'd0;
        lane = 0;
        for (int i = 0; i < ps.size(); i++) begin
            w[lane*8 +: 8] = ref_byte(ps[i], int'($signed(sc)), int'(sh), int'(zp));
            lane++;
            if (lane == 4 || i == ps.size() - 1) begin
                exp_q.push_back({(i == ps.size() - 1), w});
                w = 32'd0;
                lane = 0;
            end
        end
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Downstream ready: always, random, or held low.
    initial begin
        bus.ofmap_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.ofmap_ready = 1'b1;
                1: bus.ofmap_ready = ($urandom_range(0, 3) != 0);
                default: bus.ofmap_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard, stall stability, done pulse timing.
    initial begin
        bit          hold_prev;
        bit          done_exp;
        logic [31:0] word_prev;
        logic        last_prev;
        logic [32:0] e;
        hold_prev = 1'b0;
        done_exp  = 1'b0;
        word_prev = 32'd0;
        last_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_prev = 1'b0;
                done_exp  = 1'b0;
            end else begin
                if (done_exp || done) check_val("done_pulse", 64'(done), 64'(done_exp));
                if (done) done_cnt++;
                done_exp = 1'b0;
                if (hold_prev) begin
                    check_val("stall_valid_held", 64'(bus.ofmap_valid), 64'd1);
                    check_val("stall_word_stable", 64'({bus.ofmap_last, bus.ofmap}),
                              64'({last_prev, word_prev}));
                end
                if (bus.ofmap_valid && !bus.ofmap_ready)
                    check_val("stall_psum_ready", 64'(bus.psum_ready), 64'd0);
                if (bus.ofmap_valid && bus.ofmap_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("word_unexpected", 64'({bus.ofmap_last, bus.ofmap}), 64'h1_0000_0000_0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("ofmap_word", 64'({bus.ofmap_last, bus.ofmap}), 64'(e));
                    end
                    if (bus.ofmap_last) begin
                        done_exp = 1'b1;
                        last_word_cyc = cyc;
                    end
                end
                hold_prev = bus.ofmap_valid && !bus.ofmap_ready;
                word_prev = bus.ofmap;
                last_prev = bus.ofmap_last;
            end
        end
    end

    task automatic start_tile(input logic [15:0] sc, input logic [4:0] sh, input logic [7:0] zp,
                              input logic [9:0] cnt);
        @(posedge clk);
        #1;
        cfg_scale      = sc;
        cfg_shift      = sh;
        cfg_zero_point = zp;
        cfg_count      = cnt;
        cfg_en         = 1'b1;
        @(posedge clk);
        #1;
        cfg_en = 1'b0;
        check_val("busy_after_cfg", 64'(busy), 64'd1);
        check_val("psum_ready_after_cfg", 64'(bus.psum_ready), 64'd1);
    endtask

    task automatic send_psum(input int p, input int gap);
        bit accepted;
        int waited;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.psum       = p;
        bus.psum_valid = 1'b1;
        accepted = 1'b0;
        waited   = 0;
        while (!accepted && waited < 1000) begin
            @(negedge clk);
            if (bus.psum_ready) begin
                @(posedge clk);
                #1;
                accepted     = 1'b1;
                last_acc_cyc = cyc;
            end else begin
                waited++;
            end
        end
        if (!accepted) check_val("psum_accept_timeout", 64'd0, 64'd1);
        bus.psum_valid = 1'b0;
    endtask

    task automatic wait_tile_end(input int start_cnt);
        int w;
        w = 0;
        while (done_cnt == start_cnt && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check_val("done_seen", 64'(done_cnt != start_cnt), 64'd1);
        check_val("exp_drained", 64'(exp_q.size()), 64'd0);
        check_val("idle_busy", 64'(busy), 64'd0);
        check_val("idle_psum_ready", 64'(bus.psum_ready), 64'd0);
    endtask

    task automatic run_tile(input logic [15:0] sc, input logic [4:0] sh, input logic [7:0] zp,
                            input logic [9:0] cnt, input int ps[$], input bit use_model,
                            input int gap_max);
        int start;
        if (use_model) model_tile(sc, sh, zp, ps);
        start = done_cnt;
        start_tile(sc, sh, zp, cnt);
        foreach (ps[i]) send_psum(ps[i], $urandom_range(0, gap_max));
        wait_tile_end(start);
    endtask

    task automatic check_reset_outputs(input string phase);
        check_val({phase, "_psum_ready"}, 64'(bus.psum_ready), 64'd0);
        check_val({phase, "_ofmap"}, 64'(bus.ofmap), 64'd0);
        check_val({phase, "_ofmap_valid"}, 64'(bus.ofmap_valid), 64'd0);
        check_val({phase, "_ofmap_last"}, 64'(bus.ofmap_last), 64'd0);
        check_val({phase, "_busy"}, 64'(busy), 64'd0);
        check_val({phase, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ps[$];
        int n;
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        rdy_mode = 0;
        rst = 1'b0;
        cfg_en = 1'b0;
        cfg_scale = 16'd0;
        cfg_shift = 5'd0;
        cfg_zero_point = 8'd0;
        cfg_count = 10'd0;
        bus.psum = 32'd0;
        bus.psum_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Identity, plus latency from last accept to word.
        exp_q.push_back({1'b1, 32'h04030201});
        ps = '{1, 2, 3, 4};
        run_tile(16'd1, 5'd0, 8'd0, 10'd4, ps, 1'b0, 0);
        check_val("latency", 64'(last_word_cyc - last_acc_cyc), 64'd2);

        // Round and saturate.
        exp_q.push_back({1'b1, 32'h0CFF000E});
        ps = '{5, -100, 1000, 2};
        run_tile(16'd3, 5'd2, 8'd10, 10'd4, ps, 1'b0, 1);

        // Partial trailing word.
        exp_q.push_back({1'b0, 32'h04030201});
        exp_q.push_back({1'b1, 32'h00000605});
        ps = '{1, 2, 3, 4, 5, 6};
        run_tile(16'd1, 5'd0, 8'd0, 10'd6, ps, 1'b0, 0);

        // Negative sum with zero point.
`ifdef OPSUM_REQUANT_RELU_EN
        exp_q.push_back({1'b1, 32'h00000080});
`else
        exp_q.push_back({1'b1, 32'h0000007B});
`endif
        ps = '{-5};
        run_tile(16'd1, 5'd0, 8'd128, 10'd1, ps, 1'b0, 0);

        // A count of 0 behaves as a single-element tile.
        ps = '{77};
        run_tile(16'd2, 5'd1, 8'd3, 10'd0, ps, 1'b1, 0);

        // Backpressure: hold ready low for several cycles once a word is valid.
        ps = '{10, 20, 30, 40, 50, 60, 70, 80};
        rdy_mode = 2;
        fork
            run_tile(16'd1, 5'd0, 8'd0, 10'd8, ps, 1'b1, 0);
            begin
                int w;
                w = 0;
                while (!bus.ofmap_valid && w < 500) begin
                    @(negedge clk);
                    w++;
                end
                check_val("bp_word_appeared", 64'(bus.ofmap_valid), 64'd1);
                repeat (5) @(negedge clk);
                rdy_mode = 0;
            end
        join

        // Reset in the middle of a tile.
        start_tile(16'd1, 5'd0, 8'd0, 10'd8);
        send_psum(11, 0);
        send_psum(12, 0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_q.delete();
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check_reset_outputs("postreset");
        ps = '{9, 8, 7, 6, 5, 4, 3, 2};
        run_tile(16'd1, 5'd0, 8'd0, 10'd8, ps, 1'b1, 0);

        // Randomized tiles under random downstream backpressure.
        rdy_mode = 1;
        for (int t = 0; t < 40; t++) begin
            logic [9:0] cnt;
            cnt = 10'($urandom_range(0, 13));
            n = (cnt == 10'd0) ? 1 : int'(cnt);
            ps.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 0) ps.push_back(int'($urandom_range(0, 4000)) - 2000);
                else ps.push_back(int'($urandom));
            end
            run_tile(16'($urandom), 5'($urandom_range(0, 31)), 8'($urandom), cnt, ps, 1'b1, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
